// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared pipeline definitions for the unified-memory port arbiter:
//   - arb_state_t : arbiter FSM state encoding (IDLE, MEM, RESP)
//   - OWNER_IF / OWNER_D : encoding of the owner output (fetch / data)
//   - sat_inc     : saturating increment used by the starvation counter
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    // Increment cnt by one, but never beyond lim.
    function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic [3:0] lim);
        return (cnt >= lim) ? cnt : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported unified memory between instruction fetch (IF) and
// the MEM stage (D). Data accesses win arbitration unless fetch has already
// lost STARVE_MAX consecutive times, in which case fetch is forced through.
//
// Every access walks IDLE -> MEM -> RESP -> IDLE, so the minimum req-to-ack
// latency is 3 cycles and back-to-back throughput is one access per 3 cycles.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   if_req/if_addr      fetch request (held until if_ack) and address
//   if_ack/if_rdata     one-cycle completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata  data request, store flag, address, store data
//   d_ack/d_rdata       one-cycle completion pulse and load data
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory-side request
//   mem_ack/mem_rdata   memory completion (may come in first MEM cycle), data
//   owner               0 = fetch, 1 = data; current or last grant
//   busy                high while in MEM or RESP
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              owner,
    output logic              busy
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t state;
    logic [3:0] starve_cnt;
    logic       grant_d;
    logic       grant_if;

    // Arbitration is only evaluated in IDLE; requests seen in MEM/RESP are
    // ignored, which is what keeps an already-acked request from being
    // granted a second time.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned (which would infer a latch).
        grant_d  = 1'b0;
        grant_if = 1'b0;
        if (state == IDLE) begin
            if (d_req && (!if_req || (starve_cnt < STARVE_LIM))) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: datapath registers are reset too, not just control, because
            // every output must read 0 while reset is applied.
            state      <= IDLE;
            starve_cnt <= 4'd0;
            owner      <= OWNER_IF;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        owner     <= OWNER_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        state     <= MEM;
                        // Only a grant that actually made fetch wait counts
                        // towards starvation.
                        if (if_req) begin
                            starve_cnt <= sat_inc(starve_cnt, STARVE_LIM);
                        end
                    end else if (grant_if) begin
                        owner      <= OWNER_IF;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        starve_cnt <= 4'd0;
                        state      <= MEM;
                    end
                end

                MEM: begin
                    // mem_req/addr/we/wdata stay put until the memory answers.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        // Separate response registers so each requester's
                        // rdata holds its own last value.
                        if (owner == OWNER_D) begin
                            d_rdata <= mem_rdata;
                        end else begin
                            if_rdata <= mem_rdata;
                        end
                        state <= RESP;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Decoded straight from state so an async reset kills them immediately.
    assign if_ack = (state == RESP) && (owner == OWNER_IF);
    assign d_ack  = (state == RESP) && (owner == OWNER_D);
    assign busy   = (state != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-ported unified memory between the instruction-fetch stage and the MEM stage of the 64-bit RISC-V pipeline.
- Data accesses have fixed priority over fetch. A starvation counter guarantees fetch progress.
- Each requester sees a req/ack handshake. The requester stalls its pipeline stage until ack.
- The block sits between the IF/MEM stage logic and the memory model. It owns all sequencing of the memory port.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width
- STARVE_MAX, 4, consecutive data grants while fetch waits before fetch is forced; range 1–15

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address, stable while if_req high
- if_ack  out  1  one-cycle pulse, fetch complete
- if_rdata  out  DATA_W  fetched word, valid while if_ack high
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load; stable while d_req high
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle pulse, data access complete
- d_rdata  out  DATA_W  load data, valid while d_ack high
- mem_req  out  1  memory access request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion; may assert in the first mem_req cycle
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- owner  out  1  0 = fetch, 1 = data; current/last grant
- busy  out  1  high in MEM and RESP states

## Operation
- Reset: state IDLE, starve_cnt 0, owner 0. All outputs 0.
- FSM states: IDLE, MEM, RESP.

IDLE:
- If neither request is high, stay in IDLE.
- If only one request is high, grant it.
- If both are high, grant data when starve_cnt < STARVE_MAX, else grant fetch.
- On a grant, register the address, we and wdata from the winner, set owner, and go to MEM.
- A fetch grant always drives mem_we = 0.

MEM:
- mem_req = 1, with the registered address, we and wdata.
- On mem_ack, capture mem_rdata into the response register and go to RESP.
- Without mem_ack, stay in MEM. There is no timeout.

RESP:
- Pulse if_ack or d_ack according to owner, with rdata.
- Go to IDLE. No arbitration happens in RESP.

Starvation counter:
- On a data grant with if_req high, starve_cnt increments, saturating at STARVE_MAX.
- On a fetch grant, starve_cnt clears to 0.
- On a data grant with if_req low, starve_cnt is unchanged.

Other rules:
- d_rdata for stores is don't-care; it is driven with the captured mem_rdata.
- if_rdata and d_rdata hold their last value outside ack.
- Requester rule: deassert req, or present a new request, in the cycle after ack. Because of the RESP→IDLE cycle, the same request is never granted twice.
- Request inputs changing while not granted are legal. They are sampled only in IDLE.

## Timing
- Minimum latency is 3 cycles from req to ack:
  - cycle 0: IDLE grants;
  - cycle 1: mem_req with same-cycle mem_ack;
  - cycle 2: ack.
- With N wait cycles from memory, latency is 3+N.
- Back-to-back throughput is one access per 3 cycles. The loser of arbitration is re-evaluated in the IDLE cycle after RESP.
- mem_req, mem_addr, mem_we and mem_wdata are registered outputs. They are stable for the whole MEM state.
- Reset mid-operation (MEM or RESP):
  - All outputs drop to 0 immediately (async).
  - No ack is issued and the pending access is abandoned.
  - The memory model must tolerate an abandoned request.
- A mem_ack outside MEM is ignored.

## Structure
- Shared pipeline package:
  - state enum arb_state_t {IDLE, MEM, RESP};
  - constants OWNER_IF = 1'b0 and OWNER_D = 1'b1.
- Single module, no sub-module. The starvation counter is 4 bits, inline.

## Test plan
- Single fetch: if_req, if_addr=0x100, mem_ack in the first MEM cycle, mem_rdata=0x00500093 → if_ack at cycle 2, if_rdata=0x00500093, mem_we=0 throughout.
- Store with wait states: d_req, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, mem_ack after 3 wait cycles → mem_we=1, mem_wdata=0xDEADBEEF held 4 cycles, d_ack at cycle 5.
- Contention: if_req and d_req high together, with d_req re-presented after each ack, STARVE_MAX=4 → grant order D, D, D, D, IF; starve_cnt reads 0 after the IF grant.
- Data-only traffic: 10 loads with if_req low → starve_cnt stays 0; owner=1 on every grant.
- Reset mid-op: rst asserted in MEM with mem_req=1 → mem_req, busy and acks are 0 the same cycle; after release, IDLE and a fresh fetch completes normally.
- Stray mem_ack in IDLE with no request → no ack, state unchanged.
